stream_histogram: RTL and testbench

STREAM_HISTOGRAM -- requirements
Module: stream_histogram

---
 rtl/stream_histogram_if.sv | 11 +
 rtl/stream_histogram.sv | 128 ++++++++++++
 tb/tb_stream_histogram.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_histogram_if.sv
// Valid/ready stream bundle used for both the sample input and the packet output.
interface stream_histogram_if #(
  parameter int unsigned W = 8
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/stream_histogram.sv
// Stream histogram: per-sample duplicate detection bitmap plus saturating
// per-bin counters; each accepted sample yields one packet
// {header, bin count, storage address, sample}.
module stream_histogram #(
  parameter int unsigned          DATA_W    = 8,
  parameter int unsigned          BIN_BITS  = 3,
  parameter int unsigned          COUNT_W   = 8,
  parameter int unsigned          ADDR_W    = 12,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = 12'h020
) (
  input  logic                 aclk,
  input  logic                 areset,
  stream_histogram_if.slave    s_axis,
  stream_histogram_if.master   m_axis,
  input  logic                 clear,
  output logic                 busy,
  output logic [COUNT_W-1:0]   total_cnt,
  output logic [COUNT_W-1:0]   dup_cnt
);

  localparam int unsigned        PKT_W   = 4 + COUNT_W + ADDR_W + DATA_W;
  localparam int unsigned        DEPTH   = 2 ** DATA_W;
  localparam int unsigned        NBINS   = 2 ** BIN_BITS;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {CLEAR, IDLE, LOOKUP, EMIT} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   sample_q;
  logic [DATA_W-1:0]   clr_addr;
  logic                clr_pend;
  logic                seen [DEPTH];
  logic [COUNT_W-1:0]  bin_cnt [NBINS];
  logic [PKT_W-1:0]    pkt_q;

  logic                accept;
  logic [BIN_BITS-1:0] bin;
  logic                hit;
  logic [COUNT_W-1:0]  cnt_upd;
  logic [PKT_W-1:0]    pkt;

  assign accept = (state == IDLE) && !clear && s_axis.tvalid;

  // Lookup datapath: current bitmap bit and bin count for the registered sample.
  always_comb begin
    bin     = sample_q[DATA_W-1 -: BIN_BITS];
    hit     = seen[sample_q];
    cnt_upd = bin_cnt[bin];
    if (!hit && (bin_cnt[bin] != CNT_MAX))
      cnt_upd = bin_cnt[bin] + 1'b1;
    pkt = {(hit ? 4'h1 : 4'h0), cnt_upd,
           BASE_ADDR + ADDR_W'(sample_q), sample_q};
  end

  // State register; reset always lands in CLEAR so the bitmap gets wiped.
  always_ff @(posedge aclk) begin
    if (areset) state <= CLEAR;
    else        state <= state_nxt;
  end

  // Next-state logic; a clear seen mid-packet is deferred until the output handshake.
  always_comb begin
    state_nxt = state;
    unique case (state)
      CLEAR:  if (&clr_addr) state_nxt = IDLE;
      IDLE:   if (clear) state_nxt = CLEAR;
              else if (s_axis.tvalid) state_nxt = LOOKUP;
      LOOKUP: state_nxt = EMIT;
      EMIT:   if (m_axis.tready) state_nxt = (clr_pend || clear) ? CLEAR : IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  // Output decode.
  always_comb begin
    s_axis.tready = (state == IDLE) && !clear;
    m_axis.tvalid = (state == EMIT);
    m_axis.tdata  = pkt_q;
    busy          = (state == CLEAR) || clr_pend;
  end

  // Pending clear request latched while a sample is in flight.
  always_ff @(posedge aclk) begin
    if (areset || state == CLEAR)
      clr_pend <= 1'b0;
    else if (clear && (state == LOOKUP || state == EMIT))
      clr_pend <= 1'b1;
  end

  // Wipe address walks 0..DEPTH-1 while in CLEAR, parked at 0 otherwise.
  always_ff @(posedge aclk) begin
    if (areset || state != CLEAR) clr_addr <= '0;
    else                          clr_addr <= clr_addr + 1'b1;
  end

  // Input sample register.
  always_ff @(posedge aclk) begin
    if (accept) sample_q <= s_axis.tdata;
  end

  // Bitmap: one entry cleared per CLEAR cycle, entry set on each lookup.
  always_ff @(posedge aclk) begin
    if (state == CLEAR)       seen[clr_addr] <= 1'b0;
    else if (state == LOOKUP) seen[sample_q] <= 1'b1;
  end

  // Saturating bin, total and duplicate counters.
  always_ff @(posedge aclk) begin
    if (areset || state == CLEAR) begin
      total_cnt <= '0;
      dup_cnt   <= '0;
      for (int unsigned i = 0; i < NBINS; i++) bin_cnt[i] <= '0;
    end else begin
      if (accept && total_cnt != CNT_MAX) total_cnt <= total_cnt + 1'b1;
      if (state == LOOKUP) begin
        bin_cnt[bin] <= cnt_upd;
        if (hit && dup_cnt != CNT_MAX) dup_cnt <= dup_cnt + 1'b1;
      end
    end
  end

  // Packet register, loaded in LOOKUP and held through EMIT.
  always_ff @(posedge aclk) begin
    if (areset)               pkt_q <= '0;
    else if (state == LOOKUP) pkt_q <= pkt;
  end

endmodule

// File: tb/tb_stream_histogram.sv
// Bench for stream_histogram: two instances (COUNT_W 8 and 4) driven in
// lockstep and compared against an array-based reference model.
module tb_stream_histogram;

  logic       aclk = 1'b0;
  logic       areset;
  logic       clear;
  logic       busy8, busy4;
  logic [7:0] total8, dup8;
  logic [3:0] total4, dup4;

  stream_histogram_if #(.W(8))  s8 ();
  stream_histogram_if #(.W(32)) m8 ();
  stream_histogram_if #(.W(8))  s4 ();
  stream_histogram_if #(.W(28)) m4 ();

  stream_histogram #(.DATA_W(8), .BIN_BITS(3), .COUNT_W(8), .ADDR_W(12), .BASE_ADDR(12'h020)) dut8 (
    .aclk(aclk), .areset(areset), .s_axis(s8), .m_axis(m8),
    .clear(clear), .busy(busy8), .total_cnt(total8), .dup_cnt(dup8));

  stream_histogram #(.DATA_W(8), .BIN_BITS(3), .COUNT_W(4), .ADDR_W(12), .BASE_ADDR(12'h020)) dut4 (
    .aclk(aclk), .areset(areset), .s_axis(s4), .m_axis(m4),
    .clear(clear), .busy(busy4), .total_cnt(total4), .dup_cnt(dup4));

  always #5 aclk = ~aclk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model state
  bit seen_m [256];
  int bin_n  [8];
  int total_n, dup_n;
  logic [31:0] exp8, last8;
  logic [27:0] exp4;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) seen_m[i] = 1'b0;
    for (int i = 0; i < 8; i++) bin_n[i] = 0;
    total_n = 0;
    dup_n   = 0;
  endtask

  task automatic model_accept(input logic [7:0] s);
    int  b, addr;
    bit  hit;
    longint c8, c4, hdr;
    hit = seen_m[s];
    b   = int'(s) / 32;
    if (hit) dup_n++;
    else     bin_n[b]++;
    seen_m[s] = 1'b1;
    total_n++;
    hdr  = hit ? 1 : 0;
    c8   = sat(bin_n[b], 255);
    c4   = sat(bin_n[b], 15);
    addr = (32 + int'(s)) % 4096;
    exp8 = 32'(hdr * (longint'(1) << 28) + c8 * (1 << 20) + addr * 256 + int'(s));
    exp4 = 28'(hdr * (1 << 24) + c4 * (1 << 20) + addr * 256 + int'(s));
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_total8"}, 64'(total8), 64'(sat(total_n, 255)));
    chk({tag, "_dup8"},   64'(dup8),   64'(sat(dup_n, 255)));
    chk({tag, "_total4"}, 64'(total4), 64'(sat(total_n, 15)));
    chk({tag, "_dup4"},   64'(dup4),   64'(sat(dup_n, 15)));
  endtask

  // Count cycles until the block is accepting input again after a wipe.
  task automatic wait_clear(input string tag);
    int n = 0;
    chk({tag, "_busy_start"}, 64'(busy8), 64'd1);
    while (!s8.tready && n < 2000) begin
      tick();
      n++;
    end
    chk({tag, "_clear_cycles"}, 64'(n), 64'd256);
    chk({tag, "_busy_end8"}, 64'(busy8), 64'd0);
    chk({tag, "_busy_end4"}, 64'(busy4), 64'd0);
    check_counters(tag);
  endtask

  task automatic do_reset();
    areset = 1'b1; clear = 1'b0;
    s8.tvalid = 1'b0; s4.tvalid = 1'b0; s8.tdata = '0; s4.tdata = '0;
    m8.tready = 1'b0; m4.tready = 1'b0;
    tick();
    tick();
    chk("rst_tvalid8", 64'(m8.tvalid), 64'd0);
    chk("rst_tdata8",  64'(m8.tdata),  64'd0);
    chk("rst_tdata4",  64'(m4.tdata),  64'd0);
    chk("rst_sready",  64'(s8.tready), 64'd0);
    chk("rst_busy",    64'(busy8),     64'd1);
    chk("rst_total",   64'(total8),    64'd0);
    chk("rst_dup",     64'(dup8),      64'd0);
    areset = 1'b0;
    model_clear();
    wait_clear("rst");
  endtask

  // One sample through the pipe; optional output stall and mid-EMIT clear pulse.
  task automatic send(input logic [7:0] s, input int stall, input bit pulse_clear);
    int n = 0;
    s8.tdata = s; s4.tdata = s;
    s8.tvalid = 1'b1; s4.tvalid = 1'b1;
    while (!s8.tready && n < 1000) begin
      tick();
      n++;
    end
    chk("accept_wait", 64'(n < 1000), 64'd1);
    chk("sready_lockstep", 64'(s4.tready), 64'd1);
    tick();
    s8.tvalid = 1'b0; s4.tvalid = 1'b0;
    model_accept(s);
    chk("tvalid_lookup", 64'(m8.tvalid), 64'd0);
    tick();
    chk("tvalid8", 64'(m8.tvalid), 64'd1);
    chk("tvalid4", 64'(m4.tvalid), 64'd1);
    chk("pkt8", 64'(m8.tdata), 64'(exp8));
    chk("pkt4", 64'(m4.tdata), 64'(exp4));
    check_counters("pkt");
    last8 = m8.tdata;
    if (pulse_clear) begin
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_pend_busy", 64'(busy8), 64'd1);
      chk("clr_pend_tvalid", 64'(m8.tvalid), 64'd1);
    end
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_tvalid", 64'(m8.tvalid), 64'd1);
      chk("stall_tdata",  64'(m8.tdata),  64'(exp8));
      chk("stall_sready", 64'(s8.tready), 64'd0);
    end
    m8.tready = 1'b1; m4.tready = 1'b1;
    tick();
    m8.tready = 1'b0; m4.tready = 1'b0;
    chk("tvalid_after_hs", 64'(m8.tvalid), 64'd0);
    if (pulse_clear) begin
      model_clear();
      wait_clear("midclr");
    end
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s;
    do_reset();

    send(8'h07, 0, 1'b0);
    chk("first_pkt", 64'(last8), 64'h00102707);
    send(8'h07, 0, 1'b0);
    chk("dup_pkt", 64'(last8), 64'h10102707);
    chk("dup_cnt_1", 64'(dup8), 64'd1);
    chk("total_2", 64'(total8), 64'd2);
    send(8'hE0, 0, 1'b0);
    chk("pkt_e0", 64'(last8), 64'h001100E0);
    send(8'hFF, 0, 1'b0);
    chk("pkt_ff", 64'(last8), 64'h00211FFF);

    send(8'h33, 20, 1'b0);
    send(8'h40, 2, 1'b1);
    send(8'h07, 0, 1'b0);
    chk("after_clear_new", 64'(last8), 64'h00102707);

    for (int i = 0; i < 300; i++) begin
      s = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(0, 255));
      send(s, 0, 1'b0);
    end
    chk("bin0_sat4", 64'(sat(bin_n[0], 15)), 64'd15);
    chk("total4_sat", 64'(total4), 64'd15);
    chk("total8_sat", 64'(total8), 64'd255);

    // Reset while a packet is being offered: it is dropped.
    s8.tdata = 8'h55; s4.tdata = 8'h55; s8.tvalid = 1'b1; s4.tvalid = 1'b1;
    tick();
    s8.tvalid = 1'b0; s4.tvalid = 1'b0;
    tick();
    chk("pre_rst_tvalid", 64'(m8.tvalid), 64'd1);
    areset = 1'b1;
    tick();
    chk("midrst_tvalid", 64'(m8.tvalid), 64'd0);
    chk("midrst_tdata",  64'(m8.tdata),  64'd0);
    chk("midrst_busy",   64'(busy8),     64'd1);
    chk("midrst_total",  64'(total8),    64'd0);
    areset = 1'b0;
    model_clear();
    wait_clear("midrst");
    send(8'h55, 0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
